// File: rtl/sap2_pkg.sv
// Shared SAP-2 definitions: opcode constants, fetch-state encoding and the
// instruction length decode used by both the fetch stage and the decoder.
package sap2_pkg;

  localparam int SAP2_ADDR_W = 16;
  localparam int SAP2_DATA_W = 8;

  // Three-byte instructions (opcode + 16-bit operand)
  localparam logic [7:0] OP_JMP  = 8'hC3;
  localparam logic [7:0] OP_CALL = 8'hCD;
  localparam logic [7:0] OP_JM   = 8'hFA;
  localparam logic [7:0] OP_JZ   = 8'hCA;
  localparam logic [7:0] OP_JNZ  = 8'hC2;
  localparam logic [7:0] OP_LDA  = 8'h3A;
  localparam logic [7:0] OP_STA  = 8'h32;

  // Two-byte instructions (opcode + 8-bit operand)
  localparam logic [7:0] OP_MVIA = 8'h3E;
  localparam logic [7:0] OP_MVIB = 8'h06;
  localparam logic [7:0] OP_MVIC = 8'h0E;
  localparam logic [7:0] OP_ANI  = 8'hE6;
  localparam logic [7:0] OP_ORI  = 8'hF6;
  localparam logic [7:0] OP_XRI  = 8'hEE;
  localparam logic [7:0] OP_IN   = 8'hDB;
  localparam logic [7:0] OP_OUT  = 8'hD3;

  typedef enum logic [1:0] {
    FETCH_OP,
    FETCH_LO,
    FETCH_HI,
    HOLD
  } fetch_state_t;

  function automatic logic [1:0] instr_len(input logic [7:0] opcode);
    case (opcode)
      OP_JMP, OP_CALL, OP_JM, OP_JZ, OP_JNZ, OP_LDA, OP_STA:           return 2'd3;
      OP_MVIA, OP_MVIB, OP_MVIC, OP_ANI, OP_ORI, OP_XRI, OP_IN, OP_OUT: return 2'd2;
      default:                                                         return 2'd1;
    endcase
  endfunction

endpackage

// File: rtl/instr_fetch.sv
// SAP-2 instruction fetch: pulls 1-3 bytes at pc_in, steps the PC per byte and
// hands the assembled instruction to the decoder; decoder redirects reload the PC.
module instr_fetch
  import sap2_pkg::*;
#(
  parameter int ADDR_W = SAP2_ADDR_W,
  parameter int DATA_W = SAP2_DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              pc_inc,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_load_val,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic [DATA_W-1:0] ir_opcode,
  output logic [15:0]       ir_operand,
  output logic [1:0]        ir_len,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_addr
);

  fetch_state_t state_reg;
  logic         fetching;

  // Requests are withdrawn on flush and held off while reset is asserted.
  assign fetching    = reset_n && !flush && (state_reg != HOLD);
  assign mem_rd      = fetching;
  assign mem_addr    = pc_in;
  assign pc_inc      = fetching && mem_ack;
  assign pc_load     = reset_n && flush;
  assign pc_load_val = pc_load ? flush_addr : '0;
  assign ir_valid    = (state_reg == HOLD);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= FETCH_OP;
      ir_opcode  <= '0;
      ir_operand <= '0;
      ir_len     <= '0;
    end else if (flush) begin
      // Partial bytes are simply abandoned; the next opcode fetch overwrites them.
      state_reg <= FETCH_OP;
    end else begin
      case (state_reg)
        FETCH_OP: if (mem_ack) begin
          ir_opcode  <= mem_rdata;
          ir_operand <= '0;
          ir_len     <= instr_len(mem_rdata);
          state_reg  <= (instr_len(mem_rdata) == 2'd1) ? HOLD : FETCH_LO;
        end
        FETCH_LO: if (mem_ack) begin
          ir_operand[7:0] <= mem_rdata;
          state_reg       <= (ir_len == 2'd3) ? FETCH_HI : HOLD;
        end
        FETCH_HI: if (mem_ack) begin
          ir_operand[15:8] <= mem_rdata;
          state_reg        <= HOLD;
        end
        HOLD: if (ir_ready) begin
          state_reg <= FETCH_OP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: a memory/PC environment, a reference
// instruction model, directed scenarios and a randomized run with flushes.
`timescale 1ns/1ps
module tb_instr_fetch;

  typedef struct packed {
    logic [7:0]  op;
    logic [15:0] opnd;
    logic [1:0]  len;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] pc_in;
  logic        pc_inc, pc_load, mem_rd, mem_ack, ir_valid, ir_ready, flush;
  logic [15:0] pc_load_val, mem_addr, flush_addr, ir_operand;
  logic [7:0]  mem_rdata, ir_opcode;
  logic [1:0]  ir_len;

  instr_fetch dut (
    .clk(clk), .reset_n(reset_n), .pc_in(pc_in), .pc_inc(pc_inc),
    .pc_load(pc_load), .pc_load_val(pc_load_val), .mem_rd(mem_rd),
    .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ir_valid(ir_valid), .ir_ready(ir_ready), .ir_opcode(ir_opcode),
    .ir_operand(ir_operand), .ir_len(ir_len), .flush(flush),
    .flush_addr(flush_addr)
  );

  always #10 clk = ~clk;

  logic [7:0]  mem [0:65535];
  logic [15:0] pc, pc_reset = 16'h0000;
  assign mem_rdata = mem[mem_addr];
  assign pc_in     = pc;

  // Program counter the fetch stage sits behind
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)     pc <= pc_reset;
    else if (pc_load) pc <= pc_load_val;
    else if (pc_inc)  pc <= pc + 16'd1;
  end

  int checks = 0, errors = 0, hs_cnt = 0;
  int waits_cfg = 0, wait_left = 0;
  bit ready_force = 1'b1, ready_val = 1'b1, rand_flush = 1'b0, flush_req = 1'b0;
  logic [15:0] flush_addr_req = 16'h0000, cur_start = 16'h0000;
  exp_t exp_q[$];
  logic [15:0] addr_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      if (errors <= 40) $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [1:0] ref_len(input logic [7:0] op);
    if (op inside {8'hC3, 8'hCD, 8'hFA, 8'hCA, 8'hC2, 8'h3A, 8'h32}) return 2'd3;
    if (op inside {8'h3E, 8'h06, 8'h0E, 8'hE6, 8'hF6, 8'hEE, 8'hDB, 8'hD3}) return 2'd2;
    return 2'd1;
  endfunction

  function automatic exp_t ref_instr(input logic [15:0] a);
    exp_t e;
    logic [15:0] a1, a2;
    a1 = a + 16'd1;
    a2 = a + 16'd2;
    e.op   = mem[a];
    e.len  = ref_len(e.op);
    e.opnd = 16'h0000;
    if (e.len >= 2'd2) e.opnd[7:0]  = mem[a1];
    if (e.len == 2'd3) e.opnd[15:8] = mem[a2];
    return e;
  endfunction

  function automatic logic [45:0] all_outs();
    return {pc_inc, pc_load, pc_load_val, mem_rd, ir_valid, ir_opcode, ir_operand, ir_len};
  endfunction

  // Environment driver: memory acks, decoder ready/flush, and expectation upkeep
  initial begin
    bit hs;
    exp_t e;
    flush = 1'b0; flush_addr = 16'h0000; ir_ready = 1'b0; mem_ack = 1'b0;
    forever begin
      @(negedge clk);
      flush      = flush_req;
      flush_addr = flush_addr_req;
      flush_req  = 1'b0;
      if (rand_flush && $urandom_range(0, 19) == 0) begin
        flush      = 1'b1;
        flush_addr = 16'($urandom);
      end
      ir_ready = ready_force ? ready_val : 1'($urandom_range(0, 1));
      mem_ack  = 1'b0;
      if (reset_n && !ir_valid) begin
        if (wait_left <= 0) begin
          mem_ack   = 1'b1;
          wait_left = (waits_cfg < 0) ? int'($urandom_range(0, 2)) : waits_cfg;
        end else begin
          wait_left--;
        end
      end
      #6;
      if (reset_n) begin
        hs = ir_valid && ir_ready;
        if (flush) begin
          if (!hs && exp_q.size() > 0) void'(exp_q.pop_front());
          cur_start = flush_addr;
          exp_q.push_back(ref_instr(cur_start));
        end else if (hs) begin
          e = ref_instr(cur_start);
          cur_start = cur_start + 16'(e.len);
          exp_q.push_back(ref_instr(cur_start));
        end
      end
    end
  end

  // Monitor: bus/PC control every cycle, instruction against scoreboard while valid
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (reset_n) begin
        if (flush)
          check("flush_ctl", {pc_load, pc_load_val, mem_rd, pc_inc}, {1'b1, flush_addr, 2'b00});
        else if (ir_valid)
          check("hold_ctl", {pc_load, mem_rd, pc_inc}, 3'b000);
        else
          check("fetch_ctl", {pc_load, mem_rd, mem_addr, pc_inc}, {1'b0, 1'b1, pc, mem_ack});
        if (ir_valid) begin
          if (exp_q.size() == 0) begin
            check("ir_unexpected", {ir_valid}, 1'b0);
          end else begin
            check("ir", {ir_opcode, ir_operand, ir_len}, exp_q[0]);
            if (ir_ready) begin
              void'(exp_q.pop_front());
              hs_cnt++;
            end
          end
        end
      end
    end
  end

  task automatic do_reset(input logic [15:0] start, input int waits);
    @(negedge clk);
    #7;
    pc_reset  = start;
    reset_n   = 1'b0;
    waits_cfg = waits;
    wait_left = (waits < 0) ? 0 : waits;
    repeat (2) @(posedge clk);
    exp_q.delete();
    cur_start = start;
    exp_q.push_back(ref_instr(start));
    #2 reset_n = 1'b1;
  endtask

  task automatic run_until_valid(output int cyc, output int incs);
    cyc = 0;
    incs = 0;
    addr_q.delete();
    forever begin
      @(negedge clk);
      #5;
      if (ir_valid) break;
      if (pc_inc) begin
        incs++;
        addr_q.push_back(mem_addr);
      end
      cyc++;
      if (cyc > 60) begin
        checks++;
        errors++;
        $display("FAIL valid_timeout actual=no_ir_valid required=ir_valid_within_60");
        break;
      end
    end
  endtask

  initial begin
    logic [7:0] pool [0:14];
    int c, n;
    pool = '{8'hC3, 8'hCD, 8'hFA, 8'hCA, 8'hC2, 8'h3A, 8'h32,
             8'h3E, 8'h06, 8'h0E, 8'hE6, 8'hF6, 8'hEE, 8'hDB, 8'hD3};
    for (int i = 0; i < 65536; i++)
      mem[i] = ($urandom_range(0, 1) == 1) ? pool[$urandom_range(0, 14)] : 8'($urandom);

    // Reset values
    repeat (3) @(negedge clk);
    #5 check("reset_outs", all_outs(), 46'd0);

    // 3E 42 at 0000, zero wait
    mem[16'h0000] = 8'h3E; mem[16'h0001] = 8'h42;
    do_reset(16'h0000, 0);
    run_until_valid(c, n);
    check("t2_latency", c, 2);
    check("t2_pc_inc", n, 2);
    check("t2_ir", {ir_opcode, ir_operand, ir_len}, {8'h3E, 16'h0042, 2'd2});

    // C3 34 12 at 0010, two wait states per byte
    mem[16'h0010] = 8'hC3; mem[16'h0011] = 8'h34; mem[16'h0012] = 8'h12;
    do_reset(16'h0010, 2);
    run_until_valid(c, n);
    check("t3_latency", c, 9);
    check("t3_pc_inc", n, 3);
    check("t3_ir", {ir_opcode, ir_operand, ir_len}, {8'hC3, 16'h1234, 2'd3});

    // One-byte 80 with the decoder stalling for five cycles
    mem[16'h0020] = 8'h80; mem[16'h0021] = 8'h00;
    ready_val = 1'b0;
    do_reset(16'h0020, 0);
    run_until_valid(c, n);
    check("t4_latency", c, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #5 check("t4_stall", {ir_valid, mem_rd, ir_opcode, ir_operand, ir_len},
                           {1'b1, 1'b0, 8'h80, 16'h0000, 2'd1});
    end
    ready_val = 1'b1;
    @(negedge clk);
    #5 check("t4_handshake", {ir_valid, ir_ready, mem_rd}, 3'b110);
    @(negedge clk);
    #5 check("t4_next_fetch", {mem_rd, mem_addr, ir_valid}, {1'b1, 16'h0021, 1'b0});

    // Flush to 0200 while FETCH_LO is being acked
    mem[16'h0030] = 8'h3E; mem[16'h0031] = 8'h77;
    mem[16'h0200] = 8'h3E; mem[16'h0201] = 8'h55;
    do_reset(16'h0030, 0);
    @(negedge clk);
    #5 check("t5_op_ack", {pc_inc, mem_addr}, {1'b1, 16'h0030});
    flush_req = 1'b1;
    flush_addr_req = 16'h0200;
    @(negedge clk);
    #5 check("t5_flush", {pc_load, pc_load_val, pc_inc, mem_rd, mem_ack},
                         {1'b1, 16'h0200, 1'b0, 1'b0, 1'b1});
    @(negedge clk);
    #5 check("t5_redirect", {mem_rd, mem_addr, ir_valid}, {1'b1, 16'h0200, 1'b0});
    run_until_valid(c, n);
    check("t5_ir", {ir_opcode, ir_operand, ir_len}, {8'h3E, 16'h0055, 2'd2});

    // Asynchronous reset pulse in FETCH_HI
    mem[16'h0040] = 8'hC3; mem[16'h0041] = 8'h01; mem[16'h0042] = 8'h02;
    do_reset(16'h0040, 0);
    repeat (3) begin
      @(negedge clk);
      #5;
    end
    check("t6_in_hi", {mem_rd, mem_addr, ir_valid}, {1'b1, 16'h0042, 1'b0});
    #2 reset_n = 1'b0;
    #1 check("t6_async_outs", all_outs(), 46'd0);
    wait_left = 0;
    repeat (2) @(posedge clk);
    exp_q.delete();
    cur_start = 16'h0040;
    exp_q.push_back(ref_instr(16'h0040));
    #2 reset_n = 1'b1;
    run_until_valid(c, n);
    check("t6_restart", {c, n}, {32'd3, 32'd3});

    // CD at FFFE wraps the PC
    mem[16'hFFFE] = 8'hCD; mem[16'hFFFF] = 8'h11; mem[16'h0000] = 8'h22;
    do_reset(16'hFFFE, -1);
    run_until_valid(c, n);
    check("t7_pc_inc", n, 3);
    if (addr_q.size() == 3)
      check("t7_addrs", {addr_q[0], addr_q[1], addr_q[2]}, {16'hFFFE, 16'hFFFF, 16'h0000});
    else
      check("t7_addr_count", addr_q.size(), 3);
    check("t7_ir", {ir_opcode, ir_operand, ir_len}, {8'hCD, 16'h2211, 2'd3});

    // Randomized traffic: wait states, decoder stalls and flushes
    do_reset(16'h0000, -1);
    ready_force = 1'b0;
    rand_flush = 1'b1;
    c = hs_cnt;
    repeat (4000) @(negedge clk);
    rand_flush = 1'b0;
    #5 check("random_handshakes", (hs_cnt - c) > 200, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
